// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program-counter and instruction-fetch request controller.
//
// Holds the architectural PC, presents it to an external 32-bit adder
// (add_a = pc, add_b = STEP, add_ctr = 1) and takes add_sum back as the
// sequential next PC. Issues one fetch request per PC over valid/ready,
// and handles redirects, halt and accepted-fetch counting.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   add_a/add_b/add_ctr   adder operands and control (out)
//   add_sum               adder result pc + STEP (in, same cycle)
//   req_valid/req_addr    fetch request (out), req_ready accept (in)
//   redir_valid/target    branch/jump redirect pulse and target (in)
//   halt                  level, stops fetching while high (in)
//   pc                    current PC (out)
//   fetch_cnt             accepted fetch count, wraps (out)
//   misalign_err          sticky misaligned-redirect flag (out)
//
// Optional feature: define PC_MISALIGN_TRAP_EN to trap on a misaligned
// redirect target; otherwise low bits are masked silently and
// misalign_err is tied 0.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] STEP     = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  output logic        add_ctr,
  input  logic [31:0] add_sum,
  output logic        req_valid,
  output logic [31:0] req_addr,
  input  logic        req_ready,
  input  logic        redir_valid,
  input  logic [31:0] redir_target,
  input  logic        halt,
  output logic [31:0] pc,
  output logic [31:0] fetch_cnt,
  output logic        misalign_err
);

  localparam int unsigned W = 32;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    TRAP = 2'd3
  } state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   pc_nxt;
  logic [W-1:0]   cnt_nxt;
  logic           err_q, err_nxt;
  logic           hs;
  logic [W-1:0]   tgt_masked;

  // Adder and fetch address are views of the registered PC.
  assign add_a        = pc;
  assign add_b        = STEP;
  assign add_ctr      = 1'b1;
  assign req_addr     = pc;
  assign misalign_err = err_q;

  assign hs         = req_valid & req_ready;
  assign tgt_masked = redir_target & ~W'(32'h3);

  // Next-state, next-PC and counter logic.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    cnt_nxt   = fetch_cnt;
    err_nxt   = err_q;

    case (state)
      BOOT: state_nxt = halt ? HOLD : RUN;
      RUN: begin
        if (hs)   pc_nxt    = add_sum;
        if (halt) state_nxt = HOLD;
      end
      HOLD: if (!halt) state_nxt = RUN;
      TRAP: state_nxt = TRAP;
      default: state_nxt = BOOT;
    endcase

    if (hs) cnt_nxt = fetch_cnt + W'(1);

    // Redirect wins over the handshake's add_sum; state is kept except on trap.
    if (redir_valid && (state != TRAP)) begin
      pc_nxt = tgt_masked;
`ifdef PC_MISALIGN_TRAP_EN
      if (redir_target[1:0] != 2'b00) begin
        err_nxt   = 1'b1;
        state_nxt = TRAP;
      end
`endif
    end
  end

  // State and datapath registers; req_valid tracks the RUN state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= BOOT;
      pc        <= RESET_PC;
      fetch_cnt <= '0;
      req_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      fetch_cnt <= cnt_nxt;
      req_valid <= (state_nxt == RUN);
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_nxt;
  end
`else
  assign err_q = 1'b0;
`endif

endmodule
